// File: rtl/ddr2_local_arbiter.sv
// ddr2_local_arbiter
//
// Shares the single DDR2 controller local (Avalon-style) interface between
// two requesters: m0 (processor data cache) and m1 (accelerator/DMA).
// Command slots are granted round-robin. A multi-beat write burst locks the
// port to its master until the last beat is accepted. Every accepted read
// pushes {master id, burst size} into an in-order tag FIFO, and returning
// read beats are steered to the master at the head of that FIFO.
//
// Ports:
//   phy_clk, reset_phy_clk_n     clock and asynchronous active-low reset
//   local_init_done              controller calibration complete
//   m0_* / m1_*                  master command, write data and read return
//   local_*                      controller command, write data and read data
//   err_orphan_rdata             sticky: read beat arrived with no tag pending
//
// The command path (mN_* -> local_*, local_ready -> mN_ready) and the read
// return path (local_rdata_valid -> mN_rdata_valid) are purely combinational.
// Only the grant history, burst lock and tag FIFO are registered.

module ddr2_local_arbiter #(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 256,
    parameter int BE_W      = 32,
    parameter int SIZE_W    = 7,
    parameter int TAG_DEPTH = 8
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk_n,
    input  logic              local_init_done,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [SIZE_W-1:0] m0_size,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_be,
    input  logic              m0_read_req,
    input  logic              m0_write_req,
    input  logic              m0_burstbegin,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rdata_valid,
    output logic              m0_rdata_error,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [SIZE_W-1:0] m1_size,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_be,
    input  logic              m1_read_req,
    input  logic              m1_write_req,
    input  logic              m1_burstbegin,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rdata_valid,
    output logic              m1_rdata_error,

    output logic [ADDR_W-1:0] local_address,
    output logic [SIZE_W-1:0] local_size,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic              local_burstbegin,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    input  logic              local_rdata_error,

    output logic              err_orphan_rdata
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        WR_BURST
    } state_t;

    state_t            state;
    logic              rr_last;
    logic              lock;
    logic [SIZE_W-1:0] beats_left;

    logic              owner_valid;
    logic              owner;

    logic [ADDR_W-1:0] sel_address;
    logic [SIZE_W-1:0] sel_size;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              sel_read_req;
    logic              sel_write_req;
    logic              sel_burstbegin;
    logic [SIZE_W-1:0] sel_size_eff;

    logic              grant;
    logic              accept_rd;
    logic              accept_wr;

    logic              tag_id_mem   [TAG_DEPTH];
    logic [SIZE_W-1:0] tag_size_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tag_count;
    logic [SIZE_W-1:0] rd_done;

    logic              tag_empty;
    logic              tag_full;
    logic              head_id;
    logic [SIZE_W-1:0] head_size_eff;
    logic [SIZE_W-1:0] rd_left;
    logic              beat_ok;
    logic              tag_push;
    logic              tag_pop;

    // Owner selection. A locked burst owns the port outright; otherwise a
    // lone requester wins and a tie goes to the master that was not granted
    // last. Nothing is granted before calibration completes.
    always_comb begin
        owner_valid = 1'b0;
        owner       = 1'b0;
        if (local_init_done) begin
            if (state == WR_BURST) begin
                owner_valid = 1'b1;
                owner       = lock;
            end else if ((m0_read_req | m0_write_req) && (m1_read_req | m1_write_req)) begin
                owner_valid = 1'b1;
                owner       = ~rr_last;
            end else if (m0_read_req | m0_write_req) begin
                owner_valid = 1'b1;
                owner       = 1'b0;
            end else if (m1_read_req | m1_write_req) begin
                owner_valid = 1'b1;
                owner       = 1'b1;
            end
        end
    end

    // With no owner, owner stays 0 so the data-side outputs show m0 values.
    assign sel_address    = owner ? m1_address    : m0_address;
    assign sel_size       = owner ? m1_size       : m0_size;
    assign sel_wdata      = owner ? m1_wdata      : m0_wdata;
    assign sel_be         = owner ? m1_be         : m0_be;
    assign sel_read_req   = owner ? m1_read_req   : m0_read_req;
    assign sel_write_req  = owner ? m1_write_req  : m0_write_req;
    assign sel_burstbegin = owner ? m1_burstbegin : m0_burstbegin;

    // A zero burst size counts as a single beat everywhere.
    assign sel_size_eff = (sel_size == '0) ? SIZE_W'(1) : sel_size;

    assign local_address    = sel_address;
    assign local_size       = sel_size;
    assign local_wdata      = sel_wdata;
    assign local_be         = sel_be;

    // Reads are never forwarded mid-burst or while the tag FIFO is full.
    assign local_read_req   = owner_valid & (state == IDLE) & sel_read_req & ~tag_full;
    assign local_write_req  = owner_valid & sel_write_req;
    assign local_burstbegin = owner_valid & sel_burstbegin;

    // During a burst the locked master only sees ready for write beats, so
    // a stray read from it is not acknowledged.
    assign grant = owner_valid & local_ready &
                   ((state == IDLE) ? ~(sel_read_req & tag_full) : sel_write_req);

    assign m0_ready = grant & ~owner;
    assign m1_ready = grant &  owner;

    assign accept_rd = local_read_req  & local_ready;
    assign accept_wr = local_write_req & local_ready;

    // Grant history and burst lock. rr_last only moves when a command is
    // fully accepted (a read, a single-beat write, or the final burst beat),
    // so the new grant order applies from the following cycle.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state      <= IDLE;
            rr_last    <= 1'b1;
            lock       <= 1'b0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_rd) begin
                        rr_last <= owner;
                    end else if (accept_wr) begin
                        if (sel_size_eff == SIZE_W'(1)) begin
                            rr_last <= owner;
                        end else begin
                            beats_left <= sel_size_eff - SIZE_W'(1);
                            lock       <= owner;
                            state      <= WR_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (accept_wr) begin
                        beats_left <= beats_left - SIZE_W'(1);
                        if (beats_left <= SIZE_W'(1)) begin
                            rr_last <= lock;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO status and head decode. rd_left is derived from the head's
    // size minus the beats already returned for it, so it is valid as soon
    // as an entry reaches the head.
    assign tag_empty     = (tag_count == '0);
    assign tag_full      = (tag_count == CNT_W'(TAG_DEPTH));
    assign head_id       = tag_id_mem[rd_ptr];
    assign head_size_eff = (tag_size_mem[rd_ptr] == '0) ? SIZE_W'(1) : tag_size_mem[rd_ptr];
    assign rd_left       = head_size_eff - rd_done;

    assign beat_ok  = local_rdata_valid & ~tag_empty;
    assign tag_push = accept_rd;
    assign tag_pop  = beat_ok & (rd_left == SIZE_W'(1));

    // Read return steering; the data bus itself is broadcast.
    assign m0_rdata       = local_rdata;
    assign m1_rdata       = local_rdata;
    assign m0_rdata_valid = beat_ok & ~head_id;
    assign m1_rdata_valid = beat_ok &  head_id;
    assign m0_rdata_error = beat_ok & ~head_id & local_rdata_error;
    assign m1_rdata_error = beat_ok &  head_id & local_rdata_error;

    // Tag storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge phy_clk) begin
        if (tag_push) begin
            tag_id_mem[wr_ptr]   <= owner;
            tag_size_mem[wr_ptr] <= sel_size;
        end
    end

    // Tag FIFO pointers, occupancy, head beat counter and the orphan flag.
    // Push and pop in one cycle leave the occupancy unchanged.
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tag_count        <= '0;
            rd_done          <= '0;
            err_orphan_rdata <= 1'b0;
        end else begin
            if (tag_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tag_pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_done <= '0;
            end else if (beat_ok) begin
                rd_done <= rd_done + SIZE_W'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
            if (local_rdata_valid && tag_empty) begin
                err_orphan_rdata <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// tb_ddr2_local_arbiter
//
// Directed scenarios followed by a randomized phase. Each cycle the bench
// drives inputs after the falling edge, then compares every command and
// read-return output against a reference model built from the arbitration
// rules: an owner chosen from requests and the last grant, a burst lock
// with a remaining-beat count, and a queue of {master, beats} read tags.

module tb_ddr2_local_arbiter;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 256;
    localparam int BE_W      = 32;
    localparam int SIZE_W    = 7;
    localparam int TAG_DEPTH = 8;

    logic              phy_clk;
    logic              reset_phy_clk_n;
    logic              local_init_done;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [SIZE_W-1:0] m0_size, m1_size;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0]   m0_be, m1_be;
    logic              m0_read_req, m1_read_req;
    logic              m0_write_req, m1_write_req;
    logic              m0_burstbegin, m1_burstbegin;
    logic              m0_ready, m1_ready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_rdata_valid, m1_rdata_valid;
    logic              m0_rdata_error, m1_rdata_error;
    logic [ADDR_W-1:0] local_address;
    logic [SIZE_W-1:0] local_size;
    logic [DATA_W-1:0] local_wdata;
    logic [BE_W-1:0]   local_be;
    logic              local_read_req, local_write_req, local_burstbegin;
    logic              local_ready;
    logic [DATA_W-1:0] local_rdata;
    logic              local_rdata_valid;
    logic              local_rdata_error;
    logic              err_orphan_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int mdl_last;
    int mdl_lock;
    int mdl_left;
    bit mdl_orphan;
    int q_id[$];
    int q_left[$];

    int wr_beats0;

    ddr2_local_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .SIZE_W(SIZE_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .phy_clk(phy_clk),
        .reset_phy_clk_n(reset_phy_clk_n),
        .local_init_done(local_init_done),
        .m0_address(m0_address), .m0_size(m0_size), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_burstbegin(m0_burstbegin),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
        .m0_rdata_error(m0_rdata_error),
        .m1_address(m1_address), .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_burstbegin(m1_burstbegin),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
        .m1_rdata_error(m1_rdata_error),
        .local_address(local_address), .local_size(local_size), .local_wdata(local_wdata),
        .local_be(local_be), .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_ready(local_ready),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .local_rdata_error(local_rdata_error),
        .err_orphan_rdata(err_orphan_rdata)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int effSize(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic resetModel();
        mdl_last   = 1;
        mdl_lock   = -1;
        mdl_left   = 0;
        mdl_orphan = 1'b0;
        q_id.delete();
        q_left.delete();
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // by what the controller accepts at the coming rising edge.
    task automatic evaluateModel();
        int own;
        bit full;
        bit rq[2], wq[2], bq[2];
        int sq[2];
        bit exp_lrd, exp_lwr, exp_bb;
        bit exp_rdy[2], exp_rv[2], exp_re[2];
        bit orphan_now;
        logic [ADDR_W-1:0] exp_addr;
        logic [SIZE_W-1:0] exp_size;
        logic [DATA_W-1:0] exp_wdata;
        logic [BE_W-1:0]   exp_be;

        rq[0] = m0_read_req;  rq[1] = m1_read_req;
        wq[0] = m0_write_req; wq[1] = m1_write_req;
        bq[0] = m0_burstbegin; bq[1] = m1_burstbegin;
        sq[0] = int'(m0_size); sq[1] = int'(m1_size);

        own = -1;
        if (local_init_done) begin
            if (mdl_lock >= 0) own = mdl_lock;
            else if ((rq[0] || wq[0]) && (rq[1] || wq[1])) own = 1 - mdl_last;
            else if (rq[0] || wq[0]) own = 0;
            else if (rq[1] || wq[1]) own = 1;
        end
        full    = (q_id.size() >= TAG_DEPTH);
        exp_lrd = (own >= 0) && (mdl_lock < 0) && rq[own] && !full;
        exp_lwr = (own >= 0) && wq[own];
        exp_bb  = (own >= 0) && bq[own];
        for (int n = 0; n < 2; n++) begin
            exp_rdy[n] = (own == n) && local_ready &&
                         ((mdl_lock >= 0) ? wq[n] : !(rq[n] && full));
            exp_rv[n]  = 1'b0;
            exp_re[n]  = 1'b0;
        end
        exp_addr  = (own == 1) ? m1_address : m0_address;
        exp_size  = (own == 1) ? m1_size    : m0_size;
        exp_wdata = (own == 1) ? m1_wdata   : m0_wdata;
        exp_be    = (own == 1) ? m1_be      : m0_be;

        orphan_now = 1'b0;
        if (local_rdata_valid) begin
            if (q_id.size() == 0) begin
                orphan_now = 1'b1;
            end else begin
                exp_rv[q_id[0]] = 1'b1;
                exp_re[q_id[0]] = local_rdata_error;
            end
        end

        checkOutput("m0_ready", m0_ready, exp_rdy[0]);
        checkOutput("m1_ready", m1_ready, exp_rdy[1]);
        checkOutput("local_read_req", local_read_req, exp_lrd);
        checkOutput("local_write_req", local_write_req, exp_lwr);
        checkOutput("local_burstbegin", local_burstbegin, exp_bb);
        checkOutput("local_address", local_address, exp_addr);
        checkOutput("local_size", local_size, exp_size);
        checkOutput("local_wdata", local_wdata, exp_wdata);
        checkOutput("local_be", local_be, exp_be);
        checkOutput("m0_rdata_valid", m0_rdata_valid, exp_rv[0]);
        checkOutput("m1_rdata_valid", m1_rdata_valid, exp_rv[1]);
        checkOutput("m0_rdata_error", m0_rdata_error, exp_re[0]);
        checkOutput("m1_rdata_error", m1_rdata_error, exp_re[1]);
        checkOutput("m1_rdata", m1_rdata, local_rdata);
        checkOutput("err_orphan_rdata", err_orphan_rdata, mdl_orphan);

        if (m0_ready && local_ready && m0_write_req) wr_beats0++;

        if (orphan_now) mdl_orphan = 1'b1;
        if (local_rdata_valid && q_id.size() != 0) begin
            q_left[0]--;
            if (q_left[0] == 0) begin
                void'(q_id.pop_front());
                void'(q_left.pop_front());
            end
        end
        if (exp_lrd && local_ready) begin
            q_id.push_back(own);
            q_left.push_back(effSize(sq[own]));
            mdl_last = own;
        end else if (exp_lwr && local_ready) begin
            if (mdl_lock >= 0) begin
                mdl_left--;
                if (mdl_left <= 0) begin
                    mdl_last = mdl_lock;
                    mdl_lock = -1;
                end
            end else if (effSize(sq[own]) == 1) begin
                mdl_last = own;
            end else begin
                mdl_lock = own;
                mdl_left = effSize(sq[own]) - 1;
            end
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then check.
    task automatic applyStimulus(input bit ini,
                                 input bit rd0, input bit wr0, input bit bb0, input int sz0,
                                 input bit rd1, input bit wr1, input bit bb1, input int sz1,
                                 input bit lrdy, input bit rvld, input bit rerr);
        @(negedge phy_clk);
        local_init_done   = ini;
        m0_read_req       = rd0;
        m0_write_req      = wr0;
        m0_burstbegin     = bb0;
        m0_size           = SIZE_W'(sz0);
        m1_read_req       = rd1;
        m1_write_req      = wr1;
        m1_burstbegin     = bb1;
        m1_size           = SIZE_W'(sz1);
        m0_address        = ADDR_W'($urandom);
        m1_address        = ADDR_W'($urandom);
        m0_wdata          = {8{$urandom}};
        m1_wdata          = {8{$urandom}};
        m0_be             = $urandom;
        m1_be             = $urandom;
        local_ready       = lrdy;
        local_rdata_valid = rvld;
        local_rdata_error = rerr;
        local_rdata       = {8{$urandom}};
        #1;
        evaluateModel();
    endtask

    // Return beats until the model has nothing outstanding (bounded).
    task automatic drainReads();
        int guard;
        guard = 0;
        while (q_id.size() != 0 && guard < 200) begin
            applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1'($urandom_range(0, 1)));
            guard++;
        end
        checkOutput("drain_timeout", (guard >= 200), 1'b0);
    endtask

    initial begin
        local_init_done = 0;
        {m0_read_req, m0_write_req, m0_burstbegin} = '0;
        {m1_read_req, m1_write_req, m1_burstbegin} = '0;
        m0_size = '0; m1_size = '0;
        m0_address = '0; m1_address = '0;
        m0_wdata = '0; m1_wdata = '0;
        m0_be = '0; m1_be = '0;
        local_ready = 0;
        local_rdata = '0;
        local_rdata_valid = 0;
        local_rdata_error = 0;
        wr_beats0 = 0;
        resetModel();

        reset_phy_clk_n = 1'b1;
        #1 reset_phy_clk_n = 1'b0;
        repeat (2) @(posedge phy_clk);
        #2;
        checkOutput("rst_m0_ready", m0_ready, 1'b0);
        checkOutput("rst_m1_ready", m1_ready, 1'b0);
        checkOutput("rst_local_read_req", local_read_req, 1'b0);
        checkOutput("rst_local_write_req", local_write_req, 1'b0);
        checkOutput("rst_local_burstbegin", local_burstbegin, 1'b0);
        checkOutput("rst_m0_rdata_valid", m0_rdata_valid, 1'b0);
        checkOutput("rst_err_orphan", err_orphan_rdata, 1'b0);
        @(negedge phy_clk);
        reset_phy_clk_n = 1'b1;
        $display("[TB] reset released");

        // Requests before calibration get no owner
        applyStimulus(0, 1, 0, 0, 1, 0, 1, 1, 2, 1, 0, 0);

        // Tie: alternate m0, m1, m0 on consecutive cycles
        repeat (3) applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        drainReads();

        // Write lock: m1 bursts 4 beats while m0 waits with a read
        applyStimulus(1, 1, 0, 0, 1, 0, 1, 1, 4, 1, 0, 0);
        repeat (3) applyStimulus(1, 1, 0, 0, 1, 0, 1, 0, 4, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        drainReads();

        // Backpressure during an m0 write of 3 beats
        wr_beats0 = 0;
        applyStimulus(1, 0, 1, 1, 3, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("bp_beats_accepted", 32'(wr_beats0), 32'd3);

        // Read steering: m0 size 2 then m1 size 1, three beats back
        applyStimulus(1, 1, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        repeat (3) applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);

        // Full tag FIFO: 8 reads, 9th blocked, a returned beat frees a slot
        repeat (8) applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        drainReads();

        // Orphan beat with nothing outstanding
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("orphan_sticky", err_orphan_rdata, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int op0, op1;
            op0 = int'($urandom_range(0, 3));
            op1 = int'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 19) != 0),
                          (op0 == 1), (op0 == 2), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                          (op1 == 1), (op1 == 2), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                          ($urandom_range(0, 3) != 0),
                          (q_id.size() != 0) && ($urandom_range(0, 1) == 1),
                          1'($urandom_range(0, 1)));
        end

        // Finish any burst left open by the random phase
        for (int g = 0; g < 200 && mdl_lock >= 0; g++) begin
            applyStimulus(1, 0, (mdl_lock == 0), 0, 1, 0, (mdl_lock == 1), 0, 1, 1, 0, 0);
        end
        checkOutput("lock_clear_timeout", (mdl_lock >= 0), 1'b0);

        // Reset mid-burst: m0 locks, m1 is held off, reset frees it at once
        applyStimulus(1, 0, 1, 1, 4, 0, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0);
        #1 reset_phy_clk_n = 1'b0;
        #1;
        checkOutput("rst_async_m1_ready", m1_ready, 1'b1);
        checkOutput("rst_async_m0_ready", m0_ready, 1'b0);
        checkOutput("rst_async_orphan", err_orphan_rdata, 1'b0);
        @(negedge phy_clk);
        reset_phy_clk_n = 1'b1;
        resetModel();

        // After reset m0 wins the first tie again
        repeat (2) applyStimulus(1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        drainReads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_local_arbiter.md
# ddr2_local_arbiter

Two-port arbiter that shares the single DDR2 controller local (Avalon-style) interface between two requesters: m0 (processor data cache) and m1 (accelerator/DMA). It sits between the masters and the `local_*` ports of the controller/PHY top level, and runs in the `phy_clk` domain. It grants command slots round-robin and locks the port for the full length of a write burst. It also tracks outstanding reads in an in-order tag FIFO, so each `local_rdata_valid` beat is steered to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 25, local address width
- DATA_W, 256, local data width
- BE_W, 32, byte-enable width
- SIZE_W, 7, burst size width
- TAG_DEPTH, 8, outstanding read commands held (power of two)

Ports (mN_ denotes both m0_ and m1_):
- phy_clk  in  1  sole clock
- reset_phy_clk_n  in  1  asynchronous, active-low reset
- local_init_done  in  1  controller calibration complete
- mN_address  in  ADDR_W  request address
- mN_size  in  SIZE_W  burst length in beats, 1..127
- mN_wdata  in  DATA_W  write data
- mN_be  in  BE_W  byte enables
- mN_read_req  in  1  read command
- mN_write_req  in  1  write beat
- mN_burstbegin  in  1  first beat of a burst
- mN_ready  out  1  request accepted this cycle
- mN_rdata  out  DATA_W  read data, broadcast to both masters
- mN_rdata_valid  out  1  read beat belongs to this master
- mN_rdata_error  out  1  ECC error on this master's beat
- local_address, local_size, local_wdata, local_be, local_read_req, local_write_req, local_burstbegin  out  per above  to controller
- local_ready  in  1  controller accepts command/beat
- local_rdata  in  DATA_W  controller read data
- local_rdata_valid  in  1  controller read beat valid
- local_rdata_error  in  1  controller read beat error
- err_orphan_rdata  out  1  sticky flag: read beat arrived with no outstanding tag

## Operation
- State machine: IDLE, WR_BURST.
- Owner selection in IDLE:
  - The owner is selected combinationally each cycle from masters with read_req or write_req high.
  - If only one master requests, it is the owner.
  - If both request, the master not equal to rr_last is the owner.
  - If local_init_done is low, there is no owner.
- Forwarding:
  - The owner's address, size, wdata, be, read_req, write_req and burstbegin drive the local_* outputs.
  - With no owner, local_read_req, local_write_req and local_burstbegin are 0. Other local_* outputs hold m0 values.
- mN_ready = local_ready & owner==N & local_init_done & !(mN_read_req & tag_full).
  - When the tag FIFO is full, reads are blocked: local_read_req is forced to 0.
- Read accepted (IDLE, local_read_req & local_ready):
  - Push {id, size} to the tag FIFO.
  - rr_last <= id.
  - Stay in IDLE.
- Write accepted with size==1: rr_last <= id, stay in IDLE.
- Write accepted with size>1:
  - beats_left <= size-1, lock <= id, go to WR_BURST.
  - In WR_BURST only the locked master is owner; the other master's mN_ready is 0.
  - Each accepted beat decrements beats_left.
  - When the beat accepted at beats_left==1 completes, rr_last <= lock and the state returns to IDLE.
  - Read_req from the locked master during WR_BURST is ignored (not forwarded).
- size==0 is treated as 1 by all counters.
- Read return:
  - The tag FIFO head supplies id and rd_left (loaded from size on the head becoming valid).
  - On each local_rdata_valid: m{id}_rdata_valid=1 and m{id}_rdata_error=local_rdata_error in the same cycle; rd_left decrements; at the last beat the head is popped.
  - Push and pop in the same cycle are allowed when the FIFO is not full.
- local_rdata_valid with an empty FIFO: the beat is dropped and err_orphan_rdata is set, staying set until reset.

## Timing
- Reset values:
  - state IDLE, rr_last=1 (so m0 wins the first tie), beats_left=0.
  - Tag FIFO empty, err_orphan_rdata=0.
  - All mN_ready, mN_rdata_valid, local_read_req, local_write_req and local_burstbegin are 0.
- Command path is combinational, zero cycles: mN_* reaches local_* in the same cycle, and local_ready reaches mN_ready in the same cycle.
- A grant decision takes effect in the cycle after the acceptance, because rr_last and state are registered.
- Read data path is zero cycles: local_rdata_valid drives mN_rdata_valid combinationally from the FIFO head.
- Back-to-back reads from alternating masters are accepted on consecutive cycles.
- Reset assertion mid-burst or with reads outstanding clears all state immediately. Outstanding tags are discarded; the controller is reset by the same reset.

## Test plan
- Tie: m0 and m1 both assert read_req (size 1), local_ready=1 -> m0 accepted at cycle 0, m1 at cycle 1, m0 again at cycle 2. local_read_req stays high for 3 cycles.
- Write lock: m1 writes size 4 while m0 holds read_req -> four m1 beats forwarded, m0_ready=0 throughout, m0 read accepted on the cycle after the 4th beat.
- Backpressure: local_ready toggles 1,0,1,0 during an m0 write of size 3 -> beats_left decrements only on ready cycles, and exactly 3 beats are accepted.
- Read steering: m0 reads size 2, then m1 reads size 1; controller returns 3 valid beats -> m0_rdata_valid for beats 1-2, m1_rdata_valid for beat 3, FIFO empty afterwards.
- Full FIFO: 8 size-1 reads outstanding -> 9th read sees mN_ready=0 and local_read_req=0. One returned beat re-enables acceptance next cycle.
- Orphan/reset: local_rdata_valid with an empty FIFO -> err_orphan_rdata=1 and no mN_rdata_valid. Asserting reset_phy_clk_n=0 mid-write -> state IDLE and flag cleared asynchronously.
